skid_buffer: RTL

Two-entry elastic pipeline register (skid buffer) placed between datapath stages in front of the 32-bit `dff` state register. It takes a valid/ready-handshaked word from the upstream stage and presents it, registered, to the downstream stage. It sustains one transfer per cycle, and `IN_READY` is driven only from state, so no combinational path exists from `OUT_READY` to `IN_READY`. `FLUSH` discards in-flight words on a pipeline redirect.

---
 rtl/skid_buffer.sv | 98 +++++++++
 1 files changed

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer with synchronous flush, registered outputs.
// Latency: 1 cycle from input handshake to OUT_VALID when main is free or draining.
// Backpressure: absorbs one word after a downstream stall; IN_READY is a pure state decode.
module skid_buffer #(
    parameter int n = 32
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    input  logic         FLUSH,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [n-1:0] IN_D,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [n-1:0] OUT_Q,
    output logic [1:0]   COUNT
);

    // Occupancy states; the valid bits of both entries are decoded from these.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   main_q, main_d;
    logic [n-1:0]   skid_q, skid_d;
    logic           main_vld;
    logic           skid_vld;
    logic           in_fire;
    logic           out_fire;

    // Valid bits and handshake decode come only from state, never from ready inputs.
    assign main_vld  = (state_q != ST_EMPTY);
    assign skid_vld  = (state_q == ST_FULL);
    assign IN_READY  = ~skid_vld;
    assign OUT_VALID = main_vld;
    assign OUT_Q     = main_q;
    assign COUNT     = {1'b0, main_vld} + {1'b0, skid_vld};
    assign in_fire   = IN_VALID & IN_READY;
    assign out_fire  = main_vld & OUT_READY;

    // Next-state and data-load selection; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = IN_D;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = IN_D;
                    end else if (in_fire) begin
                        skid_d  = IN_D;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // IN_READY is low here, so only the drain path can happen.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and data registers, cleared immediately on reset assertion.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
